bitsim_mac_sequencer: RTL and testbench

- Per-job controller for the 16-lane signed bit-serial MAC unit.
- Accepts one job (activation vector plus sign-magnitude weight vector) over a valid/ready handshake.
- Drives the MAC's clear, activation, sign, weight-bit and column-index inputs one weight bit-column per cycle, optionally skipping all-zero columns (bit sparsity).
- Captures the accumulated dot product and returns it over a valid/ready handshake, with the count of executed columns.

---
 rtl/bitsim_pkg.sv | 20 ++
 rtl/bitsim_mac_sequencer_if.sv | 30 +++
 rtl/column_skip_encoder.sv | 30 +++
 rtl/bitsim_mac_sequencer.sv | 141 ++++++++++++++
 tb/tb_bitsim_mac_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bitsim_pkg.sv
// Shared types and sizing for the bit-serial MAC sequencer.
package bitsim_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_VEC_LENGTH = 16;
    localparam int unsigned DEF_W_MAG_BITS = 7;
    localparam int unsigned RESULT_WIDTH   = DEF_DATA_WIDTH + 17;
    localparam int unsigned COL_IDX_WIDTH  = 3;
    localparam int unsigned CYCLE_WIDTH    = 4;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        RUN,
        CAPTURE,
        DONE
    } state_t;

endpackage

// File: rtl/bitsim_mac_sequencer_if.sv
// Job-in / result-out handshake bundle of the MAC sequencer.
interface bitsim_mac_sequencer_if #(
    parameter int unsigned DATA_WIDTH = bitsim_pkg::DEF_DATA_WIDTH,
    parameter int unsigned VEC_LENGTH = bitsim_pkg::DEF_VEC_LENGTH,
    parameter int unsigned W_MAG_BITS = bitsim_pkg::DEF_W_MAG_BITS
);
    localparam int unsigned RES_W = DATA_WIDTH + 17;

    logic                                          job_valid;
    logic                                          job_ready;
    logic signed [VEC_LENGTH-1:0][DATA_WIDTH-1:0]  job_act;
    logic        [VEC_LENGTH-1:0]                  job_w_sign;
    logic        [VEC_LENGTH-1:0][W_MAG_BITS-1:0]  job_w_mag;
    logic                                          skip_en;
    logic                                          out_valid;
    logic                                          out_ready;
    logic signed [RES_W-1:0]                       out_data;
    logic        [bitsim_pkg::CYCLE_WIDTH-1:0]     out_cycles;

    modport master (
        output job_valid, job_act, job_w_sign, job_w_mag, skip_en, out_ready,
        input  job_ready, out_valid, out_data, out_cycles
    );

    modport slave (
        input  job_valid, job_act, job_w_sign, job_w_mag, skip_en, out_ready,
        output job_ready, out_valid, out_data, out_cycles
    );

endinterface

// File: rtl/column_skip_encoder.sv
// Finds the lowest set column and the next set column above k in a column mask.
module column_skip_encoder
    import bitsim_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_W_MAG_BITS
) (
    input  logic [WIDTH-1:0]         col_mask,
    input  logic [COL_IDX_WIDTH-1:0] k,
    output logic [COL_IDX_WIDTH-1:0] first_c,
    output logic [COL_IDX_WIDTH-1:0] next_c,
    output logic                     none_c
);

    // Scan downward so the last hit is the lowest qualifying index.
    always_comb begin
        first_c = '0;
        next_c  = '0;
        none_c  = 1'b1;
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (col_mask[i]) begin
                first_c = COL_IDX_WIDTH'(i);
                if (i > int'(k)) begin
                    next_c = COL_IDX_WIDTH'(i);
                    none_c = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/bitsim_mac_sequencer.sv
// Per-job controller: streams weight bit-columns into the bit-serial MAC and
// returns the accumulated dot product with the number of executed columns.
module bitsim_mac_sequencer
    import bitsim_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned VEC_LENGTH = DEF_VEC_LENGTH,
    parameter int unsigned W_MAG_BITS = DEF_W_MAG_BITS
) (
    input  logic                                   clk,
    input  logic                                   reset,
    bitsim_mac_sequencer_if.slave                  bus,
    output logic                                   mac_clear,
    output logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]  mac_act,
    output logic [VEC_LENGTH-1:0]                  mac_sign,
    output logic [VEC_LENGTH-1:0]                  mac_w_bit,
    output logic [COL_IDX_WIDTH-1:0]               mac_column_idx,
    input  logic signed [DATA_WIDTH+16:0]          mac_result,
    output logic                                   busy
);

    state_t                                  state, next_state;
    logic [VEC_LENGTH-1:0][W_MAG_BITS-1:0]   mag_q;
    logic [W_MAG_BITS-1:0]                   mask_q, accept_mask;
    logic [COL_IDX_WIDTH-1:0]                k_q, k_next;
    logic [COL_IDX_WIDTH-1:0]                enc_first, enc_next;
    logic                                    enc_none;
    logic [CYCLE_WIDTH-1:0]                  run_cnt;
    logic [VEC_LENGTH-1:0]                   col_bits;
    logic                                    accept;

    column_skip_encoder #(.WIDTH(W_MAG_BITS)) u_enc (
        .col_mask (mask_q),
        .k        (k_q),
        .first_c  (enc_first),
        .next_c   (enc_next),
        .none_c   (enc_none)
    );

    // Non-zero columns of the offered job; all columns when skipping is off.
    always_comb begin
        accept_mask = '0;
        for (int j = 0; j < int'(VEC_LENGTH); j++) begin
            accept_mask = accept_mask | bus.job_w_mag[j];
        end
        if (!bus.skip_en) begin
            accept_mask = '1;
        end
    end

    always_comb begin
        col_bits = '0;
        for (int j = 0; j < int'(VEC_LENGTH); j++) begin
            col_bits[j] = mag_q[j][k_next];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        k_next     = k_q;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.job_valid && bus.job_ready) begin
                    accept     = 1'b1;
                    next_state = CLEAR;
                end
            end
            CLEAR: next_state = LOAD;
            LOAD: begin
                if (mask_q == '0) begin
                    next_state = CAPTURE;
                end else begin
                    next_state = RUN;
                    k_next     = enc_first;
                end
            end
            RUN: begin
                if (enc_none) next_state = CAPTURE;
                else          k_next     = enc_next;
            end
            CAPTURE: next_state = DONE;
            DONE: begin
                if (bus.out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Outputs are registered from next_state so they line up with the state they describe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mac_clear      <= 1'b1;
            mac_w_bit      <= '0;
            mac_column_idx <= '0;
            mac_act        <= '0;
            mac_sign       <= '0;
            mag_q          <= '0;
            mask_q         <= '0;
            k_q            <= '0;
            run_cnt        <= '0;
            busy           <= 1'b0;
            bus.job_ready  <= 1'b1;
            bus.out_valid  <= 1'b0;
            bus.out_data   <= '0;
            bus.out_cycles <= '0;
        end else begin
            mac_clear      <= (next_state == CLEAR);
            mac_w_bit      <= '0;
            mac_column_idx <= '0;
            if (next_state == RUN) begin
                mac_w_bit      <= col_bits;
                mac_column_idx <= k_next;
            end
            busy          <= (next_state != IDLE);
            bus.job_ready <= (next_state == IDLE);
            bus.out_valid <= (next_state == DONE);
            k_q           <= k_next;
            if (accept) begin
                mac_act  <= bus.job_act;
                mac_sign <= bus.job_w_sign;
                mag_q    <= bus.job_w_mag;
                mask_q   <= accept_mask;
                run_cnt  <= '0;
            end
            if (state == RUN) begin
                run_cnt <= run_cnt + CYCLE_WIDTH'(1);
            end
            if (state == CAPTURE) begin
                bus.out_data   <= mac_result;
                bus.out_cycles <= run_cnt;
            end
        end
    end

endmodule

// File: tb/tb_bitsim_mac_sequencer.sv
// Directed bench for bitsim_mac_sequencer with a behavioural bit-serial MAC.
module tb_bitsim_mac_sequencer;
    import bitsim_pkg::*;

    localparam int unsigned DW = DEF_DATA_WIDTH;
    localparam int unsigned VL = DEF_VEC_LENGTH;
    localparam int unsigned MB = DEF_W_MAG_BITS;
    localparam int unsigned RW = RESULT_WIDTH;

    typedef logic [VL-1:0][DW-1:0] act_t;
    typedef logic [VL-1:0][MB-1:0] mag_t;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      mac_clear;
    logic [VL-1:0][DW-1:0]     mac_act;
    logic [VL-1:0]             mac_sign;
    logic [VL-1:0]             mac_w_bit;
    logic [COL_IDX_WIDTH-1:0]  mac_column_idx;
    logic signed [RW-1:0]      mac_result;
    logic                      busy;

    int total = 0;
    int bad   = 0;

    logic [COL_IDX_WIDTH-1:0]  idx_log [16];
    logic [VL-1:0]             wb_log  [16];
    logic                      clr_log [16];

    bitsim_mac_sequencer_if bus ();

    bitsim_mac_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .mac_clear      (mac_clear),
        .mac_act        (mac_act),
        .mac_sign       (mac_sign),
        .mac_w_bit      (mac_w_bit),
        .mac_column_idx (mac_column_idx),
        .mac_result     (mac_result),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // Behavioural MAC: registered act, accumulate signed shifted column each cycle.
    act_t                 act_r;
    logic signed [RW-1:0] acc;
    logic signed [RW-1:0] col_sum;

    always_comb begin
        logic signed [DW-1:0] a;
        logic signed [RW-1:0] term;
        col_sum = '0;
        a       = '0;
        term    = '0;
        for (int j = 0; j < int'(VL); j++) begin
            if (mac_w_bit[j]) begin
                a    = act_r[j];
                term = RW'(a) <<< mac_column_idx;
                if (mac_sign[j]) col_sum = col_sum - term;
                else             col_sum = col_sum + term;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mac_clear) begin
            acc   <= '0;
            act_r <= '0;
        end else begin
            act_r <= mac_act;
            acc   <= acc + col_sum;
        end
    end

    assign mac_result = acc;

    task automatic drive_job(input act_t a, input logic [VL-1:0] s, input mag_t m,
                             input logic sk, output int lat, output logic to,
                             output time t_acc);
        int n;
        to  = 1'b0;
        lat = 0;
        @(negedge clk);
        bus.job_act    = a;
        bus.job_w_sign = s;
        bus.job_w_mag  = m;
        bus.skip_en    = sk;
        bus.job_valid  = 1'b1;
        n = 0;
        while (bus.job_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            to = 1'b1;
            bus.job_valid = 1'b0;
            return;
        end
        @(posedge clk);
        t_acc = $time;
        #1;
        // Junk on the job bus after accept must not affect the result.
        bus.job_valid = 1'b0;
        bus.skip_en   = ~sk;
        for (int j = 0; j < int'(VL); j++) begin
            bus.job_act[j]   = DW'($urandom);
            bus.job_w_mag[j] = MB'($urandom);
        end
        bus.job_w_sign = VL'($urandom);
        for (int i = 0; i < 16; i++) begin
            idx_log[i] = '0;
            wb_log[i]  = '0;
            clr_log[i] = 1'b0;
        end
        idx_log[0] = mac_column_idx;
        wb_log[0]  = mac_w_bit;
        clr_log[0] = mac_clear;
        while (bus.out_valid !== 1'b1) begin
            if (lat >= 40) begin
                to = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            lat++;
            if (lat < 16) begin
                idx_log[lat] = mac_column_idx;
                wb_log[lat]  = mac_w_bit;
                clr_log[lat] = mac_clear;
            end
        end
    endtask

    task automatic release_out();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    function automatic act_t fill_act(input logic [DW-1:0] v);
        act_t r;
        for (int j = 0; j < int'(VL); j++) r[j] = v;
        return r;
    endfunction

    function automatic mag_t fill_mag(input logic [MB-1:0] v);
        mag_t r;
        for (int j = 0; j < int'(VL); j++) r[j] = v;
        return r;
    endfunction

    task automatic test_reset();
        reset          = 1'b0;
        bus.job_valid  = 1'b0;
        bus.job_act    = '0;
        bus.job_w_sign = '0;
        bus.job_w_mag  = '0;
        bus.skip_en    = 1'b0;
        bus.out_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (mac_clear !== 1'b1) begin bad++; $display("FAIL rst_mac_clear got=%b exp=1", mac_clear); end
        total++; if (mac_w_bit !== '0) begin bad++; $display("FAIL rst_w_bit got=%h exp=0", mac_w_bit); end
        total++; if (mac_column_idx !== '0) begin bad++; $display("FAIL rst_idx got=%0d exp=0", mac_column_idx); end
        total++; if (mac_act !== '0 || mac_sign !== '0) begin bad++; $display("FAIL rst_act_sign got=%h/%h exp=0", mac_act, mac_sign); end
        total++; if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rst_valid_busy got=%b/%b exp=0/0", bus.out_valid, busy); end
        total++; if (bus.out_data !== '0 || bus.out_cycles !== '0) begin bad++; $display("FAIL rst_out got=%0d/%0d exp=0/0", bus.out_data, bus.out_cycles); end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        total++; if (mac_clear !== 1'b0) begin bad++; $display("FAIL idle_mac_clear got=%b exp=0", mac_clear); end
        total++; if (bus.job_ready !== 1'b1) begin bad++; $display("FAIL idle_job_ready got=%b exp=1", bus.job_ready); end
    endtask

    task automatic test_single_column();
        int lat; logic to; time t;
        drive_job(fill_act(8'd1), '0, fill_mag(7'd1), 1'b1, lat, to, t);
        total++; if (to) begin bad++; $display("FAIL single_timeout got=timeout exp=out_valid"); end
        total++; if (lat != 4) begin bad++; $display("FAIL single_latency got=%0d exp=4", lat); end
        total++; if (bus.out_data !== 25'sd16) begin bad++; $display("FAIL single_data got=%0d exp=16", bus.out_data); end
        total++; if (bus.out_cycles !== 4'd1) begin bad++; $display("FAIL single_cycles got=%0d exp=1", bus.out_cycles); end
        total++; if (clr_log[0] !== 1'b1 || clr_log[1] !== 1'b0) begin bad++; $display("FAIL single_clear_seq got=%b%b exp=10", clr_log[0], clr_log[1]); end
        total++; if (idx_log[2] !== 3'd0 || wb_log[2] !== 16'hFFFF) begin bad++; $display("FAIL single_run got=%0d/%h exp=0/ffff", idx_log[2], wb_log[2]); end
        total++; if (wb_log[1] !== '0 || wb_log[3] !== '0) begin bad++; $display("FAIL single_wbit_idle got=%h/%h exp=0/0", wb_log[1], wb_log[3]); end
        total++; if (busy !== 1'b1 || bus.job_ready !== 1'b0) begin bad++; $display("FAIL single_busy got=%b/%b exp=1/0", busy, bus.job_ready); end
        release_out();
    endtask

    task automatic test_no_skip();
        int lat; logic to; time t;
        drive_job(fill_act(8'd1), '0, fill_mag(7'd1), 1'b0, lat, to, t);
        total++; if (to) begin bad++; $display("FAIL noskip_timeout got=timeout exp=out_valid"); end
        total++; if (lat != 10) begin bad++; $display("FAIL noskip_latency got=%0d exp=10", lat); end
        total++; if (bus.out_data !== 25'sd16) begin bad++; $display("FAIL noskip_data got=%0d exp=16", bus.out_data); end
        total++; if (bus.out_cycles !== 4'd7) begin bad++; $display("FAIL noskip_cycles got=%0d exp=7", bus.out_cycles); end
        for (int c = 0; c < 7; c++) begin
            total++; if (idx_log[2+c] !== 3'(c)) begin bad++; $display("FAIL noskip_idx%0d got=%0d exp=%0d", c, idx_log[2+c], c); end
        end
        total++; if (wb_log[2] !== 16'hFFFF || wb_log[3] !== '0) begin bad++; $display("FAIL noskip_wbit got=%h/%h exp=ffff/0", wb_log[2], wb_log[3]); end
        release_out();
    endtask

    task automatic test_neg_ramp();
        int lat; logic to; time t; act_t a;
        for (int j = 0; j < int'(VL); j++) a[j] = DW'(j - 8);
        drive_job(a, '0, fill_mag(7'd3), 1'b1, lat, to, t);
        total++; if (to) begin bad++; $display("FAIL ramp_timeout got=timeout exp=out_valid"); end
        total++; if (lat != 5) begin bad++; $display("FAIL ramp_latency got=%0d exp=5", lat); end
        total++; if (bus.out_data !== -25'sd24) begin bad++; $display("FAIL ramp_data got=%0d exp=-24", bus.out_data); end
        total++; if (bus.out_cycles !== 4'd2) begin bad++; $display("FAIL ramp_cycles got=%0d exp=2", bus.out_cycles); end
        total++; if (idx_log[2] !== 3'd0 || idx_log[3] !== 3'd1) begin bad++; $display("FAIL ramp_idx got=%0d,%0d exp=0,1", idx_log[2], idx_log[3]); end
        release_out();
    endtask

    task automatic test_sign_max();
        int lat; logic to; time t;
        drive_job(fill_act(8'd127), '1, fill_mag(7'd127), 1'b1, lat, to, t);
        total++; if (to) begin bad++; $display("FAIL max_timeout got=timeout exp=out_valid"); end
        total++; if (bus.out_data !== -25'sd258064) begin bad++; $display("FAIL max_data got=%0d exp=-258064", bus.out_data); end
        total++; if (bus.out_cycles !== 4'd7) begin bad++; $display("FAIL max_cycles got=%0d exp=7", bus.out_cycles); end
        total++; if (lat != 10) begin bad++; $display("FAIL max_latency got=%0d exp=10", lat); end
        release_out();
    endtask

    task automatic test_zero_mag();
        int lat; logic to; time t;
        drive_job(fill_act(8'd55), '0, '0, 1'b1, lat, to, t);
        total++; if (to) begin bad++; $display("FAIL zero_timeout got=timeout exp=out_valid"); end
        total++; if (lat != 3) begin bad++; $display("FAIL zero_latency got=%0d exp=3", lat); end
        total++; if (bus.out_data !== '0 || bus.out_cycles !== '0) begin bad++; $display("FAIL zero_out got=%0d/%0d exp=0/0", bus.out_data, bus.out_cycles); end
        total++; if (wb_log[2] !== '0) begin bad++; $display("FAIL zero_wbit got=%h exp=0", wb_log[2]); end
        release_out();
    endtask

    task automatic test_backpressure();
        int lat; logic to; time t;
        drive_job(fill_act(8'd1), '0, fill_mag(7'd1), 1'b1, lat, to, t);
        total++; if (to) begin bad++; $display("FAIL bp_timeout got=timeout exp=out_valid"); end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 25'sd16 || bus.job_ready !== 1'b0) begin
                bad++; $display("FAIL bp_hold%0d got=%b/%0d/%b exp=1/16/0", c, bus.out_valid, bus.out_data, bus.job_ready);
            end
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        total++; if (bus.out_valid !== 1'b0 || bus.job_ready !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL bp_release got=%b/%b/%b exp=0/1/0", bus.out_valid, bus.job_ready, busy);
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic to; time t0, t1; act_t a;
        for (int j = 0; j < int'(VL); j++) a[j] = DW'(j - 8);
        bus.out_ready = 1'b1;
        drive_job(fill_act(8'd1), '0, fill_mag(7'd1), 1'b1, lat, to, t0);
        total++; if (to || bus.out_data !== 25'sd16) begin bad++; $display("FAIL b2b_first got=%0d exp=16", bus.out_data); end
        drive_job(a, '0, fill_mag(7'd3), 1'b1, lat, to, t1);
        total++; if (to || bus.out_data !== -25'sd24) begin bad++; $display("FAIL b2b_second got=%0d exp=-24", bus.out_data); end
        total++; if (t1 - t0 != 60) begin bad++; $display("FAIL b2b_period got=%0t exp=60", t1 - t0); end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int lat; logic to; time t;
        @(negedge clk);
        bus.job_act    = fill_act(8'd9);
        bus.job_w_sign = '0;
        bus.job_w_mag  = fill_mag(7'd5);
        bus.skip_en    = 1'b0;
        bus.job_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.job_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (mac_column_idx !== 3'd1) begin bad++; $display("FAIL mid_in_run got=%0d exp=1", mac_column_idx); end
        reset = 1'b0;
        #1;
        total++; if (mac_clear !== 1'b1 || mac_w_bit !== '0 || mac_column_idx !== '0) begin
            bad++; $display("FAIL mid_rst_mac got=%b/%h/%0d exp=1/0/0", mac_clear, mac_w_bit, mac_column_idx);
        end
        total++; if (mac_act !== '0 || mac_sign !== '0) begin bad++; $display("FAIL mid_rst_act got=%h/%h exp=0/0", mac_act, mac_sign); end
        total++; if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.out_cycles !== '0 || busy !== 1'b0) begin
            bad++; $display("FAIL mid_rst_out got=%b/%0d/%0d/%b exp=0/0/0/0", bus.out_valid, bus.out_data, bus.out_cycles, busy);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        drive_job(fill_act(8'd1), '0, fill_mag(7'd1), 1'b1, lat, to, t);
        total++; if (to || lat != 4) begin bad++; $display("FAIL post_rst_latency got=%0d exp=4", lat); end
        total++; if (bus.out_data !== 25'sd16 || bus.out_cycles !== 4'd1) begin
            bad++; $display("FAIL post_rst_out got=%0d/%0d exp=16/1", bus.out_data, bus.out_cycles);
        end
        release_out();
    endtask

    initial begin
        test_reset();
        test_single_column();
        test_no_skip();
        test_neg_ramp();
        test_sign_max();
        test_zero_mag();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
